cla_subtractor: RTL and testbench



---
 rtl/cla_subtractor.sv | 109 ++++++++++
 tb/tb_cla_subtractor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_subtractor.sv
// Two-stage pipelined unsigned subtractor: diff = a - b computed as a + ~b + 1 through a flattened carry-lookahead network.
// Optional signed-overflow output enabled by defining SUB_SIGNED_OVF_EN.
`timescale 1ns/1ps

module cla_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_SIGNED_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    logic [WIDTH-1:0] a_s1;
    logic [WIDTH-1:0] b_s1;
    logic             s1_valid;
    logic             out_en;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   carry;
    logic             term;
    logic [WIDTH-1:0] diff_c;
    logic             bout_c;

    assign out_en   = !out_valid || out_ready;
    assign in_ready = !s1_valid || out_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1     <= '0;
            b_s1     <= '0;
            s1_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            a_s1     <= a;
            b_s1     <= b;
            s1_valid <= 1'b1;
        end else if (out_en) begin
            s1_valid <= 1'b0;
        end
    end

    assign p = a_s1 ^ ~b_s1;
    assign g = a_s1 & ~b_s1;

    // Each carry is an OR of independent product terms (g[j] and all higher p's, plus the all-p term
    // carrying the forced carry-in), so no carry depends on a previously computed one.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        term     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                carry[i+1] = carry[i+1] | term;
            end
            term = 1'b1;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            carry[i+1] = carry[i+1] | term;
        end
    end

    assign diff_c = p ^ carry[WIDTH-1:0];
    assign bout_c = ~carry[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
        end else if (out_en) begin
            out_valid <= s1_valid;
            diff      <= diff_c;
            bout      <= bout_c;
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    logic ovf_c;

    // Overflow only when operand signs differ and the result sign departs from the minuend's.
    assign ovf_c = (a_s1[WIDTH-1] != b_s1[WIDTH-1]) && (diff_c[WIDTH-1] != a_s1[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (out_en) begin
            ovf <= ovf_c;
        end
    end
`endif

endmodule

// File: tb/tb_cla_subtractor.sv
// Scoreboard bench for cla_subtractor: directed vectors push expected results; a monitor pops on every output transfer.
`timescale 1ns/1ps

module tb_cla_subtractor;

    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int   total;
    int   bad;
    bit   randomReady;
    bit   monEnable;
    exp_t expQ[$];
    exp_t monExp;

    cla_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
`ifdef SUB_SIGNED_OVF_EN
        .bout     (bout),
        .ovf      (ovf)
`else
        .bout     (bout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic modelOvf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        int r;
        sx = $signed(x);
        sy = $signed(y);
        r  = sx - sy;
        return (r > 15) || (r < -16);
    endfunction

    function automatic exp_t mkExp(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] d, input logic bo);
        exp_t e;
        e.d = d;
        e.b = bo;
        e.o = modelOvf(x, y);
        return e;
    endfunction

    // Monitor: every output transfer pops one expectation, so drops, duplicates and reorders all surface here.
    always @(negedge clk) begin
        if (monEnable && rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_output: got diff=%0d bout=%0d, expected no output", diff, bout);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("diff", 32'(diff), 32'(monExp.d));
                checkOutput("bout", 32'(bout), 32'(monExp.b));
`ifdef SUB_SIGNED_OVF_EN
                checkOutput("ovf", 32'(ovf), 32'(monExp.o));
`endif
            end
        end
    end

    // Entered and left just after a rising edge; holds the pair until it is accepted.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] d, input logic bo, output int cycles);
        bit accepted;
        accepted = 0;
        cycles   = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        while (!accepted && cycles < 50) begin
            @(negedge clk);
            cycles++;
            if (in_ready) begin
                accepted = 1;
                expQ.push_back(mkExp(x, y, d, bo));
            end
            @(posedge clk);
            #1;
            if (randomReady) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept within 50 cycles");
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
            if (expQ.size() != 0) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        total       = 0;
        bad         = 0;
        randomReady = 0;
        monEnable   = 1;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        out_ready   = 1'b1;

        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_diff", 32'(diff), 32'd0);
        checkOutput("rst_bout", 32'(bout), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        #5 rst_n = 1'b1;
        idleCycle();
        idleCycle();

        $display("[TB] single transaction latency");
        applyStimulus(5'd9, 5'd3, 5'd6, 1'b0, cyc);
        @(negedge clk);
        checkOutput("latency_early", 32'(out_valid), 32'd0);
        idleCycle();
        @(negedge clk);
        checkOutput("latency_valid", 32'(out_valid), 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("single_pulse", 32'(out_valid), 32'd0);
        idleCycle();

        $display("[TB] back-to-back");
        applyStimulus(5'd3, 5'd9, 5'd26, 1'b1, cyc);
        checkOutput("b2b_stall0", 32'(cyc), 32'd1);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, cyc);
        checkOutput("b2b_stall1", 32'(cyc), 32'd1);
        applyStimulus(5'd0, 5'd1, 5'd31, 1'b1, cyc);
        checkOutput("b2b_stall2", 32'(cyc), 32'd1);
        applyStimulus(5'd31, 5'd31, 5'd0, 1'b0, cyc);
        checkOutput("b2b_stall3", 32'(cyc), 32'd1);
        @(negedge clk);
        checkOutput("b2b_valid3", 32'(out_valid), 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("b2b_valid4", 32'(out_valid), 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("b2b_empty", 32'(out_valid), 32'd0);
        idleCycle();
        waitDrain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(5'd20, 5'd5, 5'd15, 1'b0, cyc);
        applyStimulus(5'd7, 5'd8, 5'd31, 1'b1, cyc);
        in_valid = 1'b1;
        a        = 5'd1;
        b        = 5'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_diff_held", 32'(diff), 32'd15);
            idleCycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_accept_on_drain", 32'(in_ready), 32'd1);
        if (in_ready) expQ.push_back(mkExp(5'd1, 5'd1, 5'd0, 1'b0));
        idleCycle();
        in_valid = 1'b0;
        waitDrain();

        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        applyStimulus(5'd20, 5'd5, 5'd15, 1'b0, cyc);
        applyStimulus(5'd7, 5'd8, 5'd31, 1'b1, cyc);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_diff", 32'(diff), 32'd0);
        checkOutput("mid_rst_bout", 32'(bout), 32'd0);
        expQ.delete();
        out_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_stale", 32'(out_valid), 32'd0);
        end
        idleCycle();
        applyStimulus(5'd9, 5'd3, 5'd6, 1'b0, cyc);
        waitDrain();

`ifdef SUB_SIGNED_OVF_EN
        $display("[TB] signed overflow");
        expQ.push_back('{d: 5'd0, b: 1'b0, o: 1'b0});
        void'(expQ.pop_back());
        in_valid = 1'b0;
        applyStimulus(5'd15, 5'd31, 5'd16, 1'b1, cyc);
        expQ[expQ.size()-1].o = 1'b1;
        applyStimulus(5'd16, 5'd1, 5'd15, 1'b0, cyc);
        expQ[expQ.size()-1].o = 1'b1;
        applyStimulus(5'd9, 5'd3, 5'd6, 1'b0, cyc);
        expQ[expQ.size()-1].o = 1'b0;
        waitDrain();
`endif

        $display("[TB] random backpressure");
        randomReady = 1;
        for (int i = 0; i < 300; i++) begin
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            applyStimulus(ra, rb, 5'(ra - rb), (ra < rb), cyc);
        end
        randomReady = 0;
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
